// File: rtl/booth_fma_pipe.sv
// booth_fma_pipe: pipelined radix-4 Booth multiply-add. The unit computes
// y = c + (neg ? -1 : 1) * a * b (mod 2^2W). It presents the result both as
// a carry-save pair and as a resolved sum.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_vld / in_rdy     input beat handshake
//   in_a, in_b          W-bit multiplicand / multiplier (b is Booth-recoded)
//   in_c                2W-bit addend
//   in_signed           1 = a, b are two's complement, 0 = unsigned
//   in_neg              1 = result is c - a*b
//   out_vld / out_rdy   result handshake
//   out_y1, out_y2      carry-save result pair (sum is the result)
//   out_y               out_y1 + out_y2, combinational from output registers
module booth_fma_pipe #(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [2*W-1:0]   in_c,
  input  logic             in_signed,
  input  logic             in_neg,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [2*W-1:0]   out_y1,
  output logic [2*W-1:0]   out_y2,
  output logic [2*W-1:0]   out_y
);

  localparam int DW   = 2 * W;
  localparam int ND   = W / 2 + 1;   // Booth digits
  localparam int NOPS = ND + 2;      // partial products + addend + correction word

  typedef logic [NOPS-1:0][DW-1:0] ops_t;

  // Number of live operands left after lvl levels of 3:2 compression.
  function automatic int ops_after(input int lvl);
    int n;
    n = NOPS;
    for (int j = 0; j < 64; j++)
      if (j < lvl) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int count_levels();
    int n;
    int c;
    n = NOPS;
    c = 0;
    for (int j = 0; j < 64; j++) begin
      if (n > 2) begin
        n = 2 * (n / 3) + n % 3;
        c++;
      end
    end
    return c;
  endfunction

  localparam int LVLS = count_levels();

  // One level of 3:2 compressors over the first n operands. Leftover
  // operands (n mod 3) pass straight through behind the compressor outputs.
  function automatic ops_t csa_level(input ops_t x, input int n);
    ops_t y;
    int   g;
    y = '0;
    g = n / 3;
    for (int j = 0; j < NOPS / 3; j++) begin
      if (j < g) begin
        y[2*j]   = x[3*j] ^ x[3*j+1] ^ x[3*j+2];
        y[2*j+1] = ((x[3*j] & x[3*j+1]) | (x[3*j] & x[3*j+2]) |
                    (x[3*j+1] & x[3*j+2])) << 1;
      end
    end
    for (int j = 0; j < NOPS; j++)
      if (j >= 3 * g && j < n) y[j-g] = x[j];
    return y;
  endfunction

  // Apply the compressor levels lo .. hi-1 of the tree.
  function automatic ops_t csa_reduce(input ops_t x, input int lo, input int hi);
    ops_t r;
    r = x;
    for (int l = 0; l < LVLS; l++)
      if (l >= lo && l < hi) r = csa_level(r, ops_after(l));
    return r;
  endfunction

  // Finish the tree from level lo and return {word2, word1}.
  function automatic logic [2*DW-1:0] csa_pair(input ops_t x, input int lo);
    ops_t r;
    r = csa_reduce(x, lo, LVLS);
    return {r[1], r[0]};
  endfunction

  // Booth recoding and partial product generation. A negative digit becomes
  // the one's complement of the magnitude. Its +1 is collected into a
  // correction word; the correction bits sit at distinct positions 2i.
  ops_t in_ops;

  always_comb begin
    logic [DW-1:0] a_ext;
    logic [DW-1:0] mag_a;
    logic [DW-1:0] corr;
    logic [W+2:0]  b_pad;
    logic [2:0]    trip;
    logic          neg;
    a_ext  = {{W{in_signed & in_a[W-1]}}, in_a};
    b_pad  = {{2{in_signed & in_b[W-1]}}, in_b, 1'b0};   // bit 0 is b[-1]
    corr   = '0;
    in_ops = '0;
    trip   = '0;
    mag_a  = '0;
    neg    = 1'b0;
    for (int i = 0; i < ND; i++) begin
      trip = b_pad[2*i +: 3];
      case (trip)
        3'b001, 3'b010, 3'b101, 3'b110: mag_a = a_ext;
        3'b011, 3'b100:                 mag_a = a_ext << 1;
        default:                        mag_a = '0;
      endcase
      // Zero digits stay zero; otherwise in_neg flips the digit's sign.
      neg       = (trip != 3'b000) && (trip != 3'b111) && (trip[2] ^ in_neg);
      in_ops[i] = (neg ? ~mag_a : mag_a) << (2 * i);
      corr[2*i] = neg;
    end
    in_ops[ND]   = in_c;
    in_ops[ND+1] = corr;
  end

  // Pipeline control: a stage advances when it is empty or its occupant
  // moves on, so bubbles collapse.
  logic [STAGES-1:0] v_q, v_d, adv, vin, load;

  always_comb begin
    adv[STAGES-1] = ~v_q[STAGES-1] | out_rdy;
    for (int k = STAGES - 2; k >= 0; k--) adv[k] = ~v_q[k] | adv[k+1];
    vin[0] = in_vld;
    for (int k = 1; k < STAGES; k++) vin[k] = v_q[k-1];
    load = adv & vin;
    v_d  = (v_q & ~adv) | load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) v_q <= '0;
    else     v_q <= v_d;
  end

  assign in_rdy  = adv[0];
  assign out_vld = v_q[STAGES-1];

  // Datapath stages. Stage k runs tree levels [k*LVLS/STAGES, (k+1)*LVLS/STAGES).
  // Data registers only load with a valid beat, so an empty pipe holds its value.
  ops_t stg_in [STAGES];
  assign stg_in[0] = in_ops;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = (k * LVLS) / STAGES;
    localparam int HI = ((k + 1) * LVLS) / STAGES;

    if (k < STAGES - 1) begin : g_mid
      ops_t ops_q, ops_d;

      always_comb ops_d = load[k] ? csa_reduce(stg_in[k], LO, HI) : ops_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) ops_q <= '0;
        else     ops_q <= ops_d;
      end

      assign stg_in[k+1] = ops_q;
    end else begin : g_out
      logic [DW-1:0] y1_q, y1_d, y2_q, y2_d;

      always_comb begin
        if (load[k]) {y2_d, y1_d} = csa_pair(stg_in[k], LO);
        else         {y2_d, y1_d} = {y2_q, y1_q};
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          y1_q <= '0;
          y2_q <= '0;
        end else begin
          y1_q <= y1_d;
          y2_q <= y2_d;
        end
      end

      assign out_y1 = y1_q;
      assign out_y2 = y2_q;
    end
  end

  assign out_y = out_y1 + out_y2;

endmodule

// File: doc/booth_fma_pipe.md
Name: booth_fma_pipe

Overview:
- Parametrised, pipelined radix-4 Booth multiply-add unit: computes a*b + c over W-bit operands with a 2W-bit addend.
- Supports signed and unsigned operands and optional product negation.
- Reduces partial products with a 3:2 carry-save tree that is split across registered pipeline stages.
- Sits in the fused_multiply_add datapath ahead of the final adder. Exposes both the carry-save pair and a resolved sum, with valid/ready flow control.

Parameters:
- W, 16, operand width; even, 4..64.
- STAGES, 2, number of registered pipeline stages from accept to out_vld; 1..4.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_vld  input  1  input beat valid.
- in_rdy  output  1  unit can accept a beat this cycle.
- in_a  input  W  multiplicand.
- in_b  input  W  multiplier (Booth-recoded operand).
- in_c  input  2W  addend.
- in_signed  input  1  1 = a and b two's complement; 0 = unsigned.
- in_neg  input  1  1 = result is c - a*b.
- out_vld  output  1  result valid.
- out_rdy  input  1  downstream accepts result.
- out_y1  output  2W  carry-save word 1.
- out_y2  output  2W  carry-save word 2.
- out_y  output  2W  out_y1 + out_y2 mod 2^2W; combinational from the output registers.

Behaviour:
- Reset: all stage valid bits are 0 and all data registers are 0.
  - After reset: out_vld=0, out_y1=out_y2=out_y=0, in_rdy=1.
  - Reset asserted mid-operation discards every in-flight beat; no partial result is ever presented.
- Handshake:
  - A beat transfers on in_vld&in_rdy; a result transfers on out_vld&out_rdy.
  - out_vld, once raised, stays high with stable out_y1/out_y2/out_y until accepted.
- Pipeline: stage k (1..STAGES) holds valid bit v[k].
  - adv[STAGES] = ~v[STAGES] | out_rdy.
  - adv[k] = ~v[k] | adv[k+1].
  - in_rdy = adv[1].
  - Bubbles collapse: a stage loads whenever it is empty or its occupant moves forward.
  - Throughput is one beat per cycle with out_rdy held high.
  - Latency: a beat accepted in cycle t gives out_vld in cycle t+STAGES if there is no backpressure.
- Simultaneous events: accept and output in the same cycle on a full pipe is legal (in_rdy=1 when out_rdy=1). Order is strictly preserved.
- Operand extension:
  - a is extended to 2W bits: sign-extended if in_signed, zero-extended otherwise.
  - b is extended to W+2 bits the same way.
- Booth digits:
  - d_i for i = 0..W/2, taken from triple {b[2i+1], b[2i], b[2i-1]} with b[-1]=0.
  - Triple-to-digit map: 000→0, 001→+1, 010→+1, 011→+2, 100→-2, 101→-1, 110→-1, 111→0.
- Partial products:
  - pp_i = d_i*a_ext << 2i, mod 2^2W.
  - A negative digit is formed as the one's complement of |d_i|*a_ext, with a +1 correction bit injected at bit 2i into the tree. No carry-propagate adder is allowed before the output.
  - in_neg: XOR is applied to the sign of every digit, flipping each digit's sign.
- Tree: operands are the W/2+1 partial products, in_c, and the correction bits. They are reduced by 3:2 compressors to two words.
  - The tree is cut at STAGES-1 internal register boundaries, balanced by compressor depth.
  - The final pair is registered in stage STAGES.
- Result invariant (exact, all wrap mod 2^2W): out_y1 + out_y2 ≡ (in_neg ? -1 : 1) * a*b + c (mod 2^2W).
  - Signed products fit in 2W bits, so no information is lost.
- out_y1 and out_y2 individually are implementation-defined. Only their sum is checked.

Test Plan:
- W=16, STAGES=2, unsigned, a=0xFFFF, b=0xFFFF, c=0, accepted in cycle 0 → out_vld in cycle 2, out_y=0xFFFE0001.
- Signed cases:
  - a=0x8000, b=0x8000, c=0 → out_y=0x40000000.
  - a=0xFFFF, b=0x0001 → 0xFFFFFFFF.
  - Same operands with in_neg=1 → 0x00000001.
- Addend wrap: unsigned a=3, b=5, c=0xFFFFFFFF → out_y=0x0000000E. With in_neg=1, c=0x10 → out_y=0x00000001.
- Backpressure: send 4 back-to-back beats (a=1..4, b=2, c=0) with out_rdy low for cycles 1-5.
  - in_rdy must drop once both stages hold beats.
  - Outputs must be 2, 4, 6, 8 in order, with none lost or duplicated, and out_y stable while stalled.
- Reset mid-flight: accept 2 beats, assert rst for 1 cycle before either emerges → out_vld=0 and out_y=0 immediately. No result appears afterwards; in_rdy=1 after reset.
- Random: 10k random beats per STAGES∈{1,2,4} and W∈{8,16,32}, random signed/neg and random out_rdy → every out_y matches the reference model, in order.
